// File: rtl/lfsr_burst_source.sv
// Multi-channel, multi-lane Galois LFSR stimulus source with a valid/ready output stream.
// Supports free-run (stop-terminated), counted burst, and replay (reseed + burst) modes.
module lfsr_burst_source #(
    parameter int          WIDTH    = 64,
    parameter int          CHANNELS = 2,
    parameter logic [31:0] SEED     = 32'h1,
    parameter int          CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [CNT_W-1:0]            burst_len,
    input  logic                        stop,
    input  logic                        reseed,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            word_count
);

    localparam int          LANES   = WIDTH / 32;
    localparam int          NLANES  = CHANNELS * LANES;
    localparam logic [31:0] POLY    = 32'h80200003;
    localparam logic [31:0] GOLDEN  = 32'h9E3779B9;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic             r_stop_pending;
    logic [CNT_W-1:0] r_word_count;
    logic [CNT_W-1:0] r_burst_len;
    logic [31:0]      r_lane [NLANES];
    logic [31:0]      w_seed [NLANES];

    logic w_idle;
    logic w_fire;
    logic w_accept;
    logic w_load;

    assign w_idle   = (r_state == S_IDLE);
    assign w_fire   = out_valid & out_ready;
    assign w_accept = w_idle & start & (mode != 2'b00);
    // Reseed and a mode-11 start both reload; a same-cycle start then sees the seed word first.
    assign w_load   = w_idle & (reseed | (start & (mode == 2'b11)));

    assign out_valid  = (r_state == S_RUN) | (r_state == S_BURST);
    assign busy       = out_valid;
    assign done       = (r_state == S_DONE);
    assign word_count = r_word_count;
    assign out_last   = ((r_state == S_RUN) & r_stop_pending) |
                        ((r_state == S_BURST) & (r_word_count == (r_burst_len - CNT_W'(1))));

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            localparam logic [31:0] K        = 32'(gi);
            localparam logic [31:0] SEED_RAW = SEED ^ (K * GOLDEN);

            assign w_seed[gi] = (SEED_RAW == 32'h0) ? 32'h1 : SEED_RAW;
            assign out_data[gi*32 +: 32] = r_lane[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_lane[gi] <= w_seed[gi];
                end else if (w_load) begin
                    r_lane[gi] <= w_seed[gi];
                end else if (w_fire) begin
                    r_lane[gi] <= {1'b0, r_lane[gi][31:1]} ^ (r_lane[gi][0] ? POLY : 32'h0);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_stop_pending <= 1'b0;
            r_word_count   <= '0;
            r_burst_len    <= '0;
        end else begin
            if (w_accept) begin
                r_word_count <= '0;
            end else if (w_fire) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_burst_len <= burst_len;
                        if (mode == 2'b01) begin
                            r_state <= S_RUN;
                        end else if (burst_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BURST;
                        end
                    end
                end
                S_RUN: begin
                    if (w_fire && out_last) begin
                        r_state <= S_DONE;
                    end else if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (w_fire && out_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_stop_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_source.sv
// Directed/randomised bench for lfsr_burst_source, checked against a word-level LFSR model.
module tb_lfsr_burst_source;

    localparam int WIDTH    = 64;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = 16;
    localparam int NL       = CHANNELS * WIDTH / 32;
    localparam int DW       = CHANNELS * WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] burst_len = '0;
    logic             stop = 1'b0;
    logic             reseed = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_count;

    lfsr_burst_source #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEED(32'h1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .burst_len(burst_len),
        .stop(stop), .reseed(reseed), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0]   m_lane [NL];
    logic [DW-1:0] q_words [$];

    function automatic logic [31:0] seed_of(int k);
        logic [31:0] s;
        s = 32'h1 ^ (32'(k) * 32'h9E3779B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic model_reseed();
        for (int k = 0; k < NL; k++) m_lane[k] = seed_of(k);
    endtask

    task automatic model_step();
        for (int k = 0; k < NL; k++) m_lane[k] = lfsr_next(m_lane[k]);
    endtask

    function automatic logic [DW-1:0] model_word();
        logic [DW-1:0] w;
        for (int k = 0; k < NL; k++) w[k*32 +: 32] = m_lane[k];
        return w;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready always, 1 random ready, 2 fixed pattern 1,0,0,1,1 then 1
    task automatic burst(input logic [1:0] md, input int n, input int rmode,
                         input bit with_reseed, input bit inject);
        int acc;
        int cyc;
        int stall;
        bit r;
        logic [DW-1:0] obs;
        logic [4:0] pat;
        pat = 5'b11001;
        start = 1'b1; mode = md; burst_len = CNT_W'(n); reseed = with_reseed;
        tick();
        start = 1'b0; reseed = 1'b0; mode = 2'b00;
        if (md == 2'b11 || with_reseed) model_reseed();
        if (n == 0) begin
            check("zero_len_valid", out_valid, 0);
            check("zero_len_done", done, 1);
            tick();
            check("zero_len_done_clear", done, 0);
            return;
        end
        acc = 0; cyc = 0; stall = 0;
        while (acc < n) begin
            check("burst_valid", out_valid, 1);
            check("burst_busy", busy, 1);
            check("burst_data", out_data, model_word());
            check("burst_last", out_last, (acc == n - 1));
            check("burst_count", word_count, acc);
            case (rmode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 1) == 1) || (stall >= 3);
                default: r = (cyc < 5) ? pat[cyc] : 1'b1;
            endcase
            stall = r ? 0 : stall + 1;
            if (inject && cyc == 1) begin
                start = 1'b1; mode = 2'b11; burst_len = 16'd7; reseed = 1'b1;
            end
            obs = out_data;
            out_ready = r;
            tick();
            start = 1'b0; reseed = 1'b0; mode = 2'b00;
            if (r) begin
                q_words.push_back(obs);
                model_step();
                acc++;
            end
            cyc++;
        end
        out_ready = 1'b1;
        check("end_valid", out_valid, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_count", word_count, n);
        tick();
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    task automatic freerun(input int stop_at, input int rmode, input int exp_words);
        int acc;
        int cyc;
        bit pend;
        bit r;
        bit stp;
        bit finished;
        start = 1'b1; mode = 2'b01;
        tick();
        start = 1'b0; mode = 2'b00;
        acc = 0; cyc = 0; pend = 0; finished = 0;
        while (!finished && cyc < 200) begin
            check("run_valid", out_valid, 1);
            check("run_data", out_data, model_word());
            check("run_last", out_last, pend);
            check("run_count", word_count, acc);
            r   = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            stp = (cyc == stop_at - 1) || (pend && cyc == stop_at + 1);
            stop = stp; out_ready = r;
            tick();
            stop = 1'b0;
            if (r) begin
                model_step();
                acc++;
                if (pend) finished = 1;
            end
            if (stp) pend = 1;
            cyc++;
        end
        out_ready = 1'b1;
        check("run_finished", finished, 1);
        if (exp_words >= 0) check("run_words", acc, exp_words);
        check("run_end_valid", out_valid, 0);
        check("run_end_done", done, 1);
        tick();
        check("run_idle_done", done, 0);
    endtask

    initial begin
        int base;
        #3 reset = 1'b0;
        #4;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", word_count, 0);
        model_reseed();
        @(negedge clk) reset = 1'b1;
        tick();
        check("rst_seed_data", out_data, model_word());
        check("rst_idle_valid", out_valid, 0);

        // Seeds and first words
        out_ready = 1'b1;
        q_words.delete();
        burst(2'b10, 4, 0, 0, 0);
        check("lane0_w0", q_words[0][31:0], 32'h00000001);
        check("lane0_w1", q_words[1][31:0], 32'h80200003);
        check("lane0_w2", q_words[2][31:0], 32'hC0300002);
        check("lane0_w3", q_words[3][31:0], 32'h60180001);
        check("lane1_w0", q_words[0][63:32], 32'h9E3779B8);

        // Backpressure, free-run with stop, continuation
        burst(2'b10, 3, 2, 0, 0);
        freerun(5, 0, 6);
        burst(2'b10, 3, 0, 0, 0);

        // Replay determinism
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        model_reseed();
        check("reseed_data", out_data, model_word());
        q_words.delete();
        burst(2'b10, 5, 1, 0, 0);
        burst(2'b11, 5, 1, 0, 0);
        for (int i = 0; i < 5; i++) check("replay_word", q_words[i + 5], q_words[i]);

        // Edge cases
        burst(2'b10, 0, 0, 0, 0);
        start = 1'b1; mode = 2'b00; burst_len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mode0_valid", out_valid, 0);
            check("mode0_busy", busy, 0);
            check("mode0_done", done, 0);
            tick();
        end
        burst(2'b10, 6, 1, 0, 1);
        base = q_words.size();
        burst(2'b10, 3, 0, 1, 0);
        check("reseed_start_w0", q_words[base][31:0], 32'h00000001);
        freerun(3, 1, -1);
        burst(2'b11, 20, 1, 0, 0);

        // Reset in the middle of a burst
        start = 1'b1; mode = 2'b10; burst_len = 16'd5; out_ready = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("pre_rst_data", out_data, model_word());
            if (i < 2) begin
                tick();
                model_step();
            end
        end
        #2 reset = 1'b0;
        #1;
        model_reseed();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", word_count, 0);
        check("mid_rst_data", out_data, model_word());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_valid", out_valid, 0);
        base = q_words.size();
        burst(2'b10, 3, 0, 0, 0);
        check("post_rst_w0", q_words[base][31:0], 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_source.md
# lfsr_burst_source

Parametrised pseudo-random stimulus source for the Koios benchmark "random I/O" wrappers. It replaces the fixed-width, always-free-running generator with a multi-channel, multi-lane LFSR bank. Output is a valid/ready stream with three run modes: free-run, counted burst, and deterministic replay. It sits between the wrapper's top-level pins and wide weight/data inputs of a compute core (e.g. LSTM weight buses), so wide buses stay non-constant without consuming I/O.

## Interface

Parameters:

- WIDTH, 64, bits per channel word; must be a multiple of 32. LANES = WIDTH/32.
- CHANNELS, 2, number of independent output words per transfer.
- SEED, 32'h1, base seed; must be nonzero.
- CNT_W, 16, width of burst_len and word_count.

Ports:

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run per mode; honoured only in IDLE.
- mode  in  2  00 none, 01 free-run, 10 burst, 11 replay (reseed + burst); sampled with start.
- burst_len  in  CNT_W  words per burst; sampled with start.
- stop  in  1  pulse; ends a free-run run.
- reseed  in  1  pulse; reloads all lanes to seed values; honoured only in IDLE.
- out_ready  in  1  consumer ready.
- out_valid  out  1  out_data valid.
- out_data  out  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]; lane i of a channel at [i*32 +: 32].
- out_last  out  1  current word is the final word of the run.
- busy  out  1  high in RUN or BURST.
- done  out  1  one-cycle pulse at the end of a run.
- word_count  out  CNT_W  words accepted since the last accepted start.

## Operation

- Lane index k = c*LANES + i. Each lane is a 32-bit Galois LFSR.
  - Seed: seed_k = SEED ^ (k * 32'h9E3779B9), truncated to 32 bits. If seed_k is 0, use 32'h1.
  - Step: s_next = (s >> 1) ^ (s[0] ? 32'h80200003 : 0).
- out_data is the concatenation of the current lane states.
- All lanes step exactly once per handshake (out_valid && out_ready), and never otherwise.
- LFSR state persists across runs. It returns to seeds only on reset, reseed, or a mode-11 start.
- States: IDLE, RUN, BURST, DONE.
  - IDLE:
    - start with mode 01 goes to RUN.
    - start with mode 10 goes to BURST.
    - start with mode 11 reloads the seeds, then goes to BURST.
    - start with mode 00 is ignored.
    - start with mode 10/11 and burst_len == 0 goes directly to DONE; no words are produced.
    - Accepted start clears word_count to 0.
  - RUN: out_valid = 1.
    - stop sets stop_pending. stop while stop_pending is already set has no extra effect.
    - out_last = stop_pending.
    - A handshake with out_last = 1 goes to DONE.
  - BURST: out_valid = 1.
    - out_last = 1 when word_count == burst_len - 1.
    - A handshake with out_last = 1 goes to DONE.
  - DONE: done = 1 and out_valid = 0 for one cycle, then IDLE. stop_pending is cleared.
- word_count increments on every handshake and wraps at 2^CNT_W.
- While out_valid = 1 and out_ready = 0, out_data and out_last are held stable.
- start, reseed and stop outside their legal states are ignored.
- reseed and start in the same IDLE cycle: reseed takes effect, then the run starts. The first word is the seed word.

## Timing

- Reset asserted, asynchronously: state IDLE, lanes at seed_k, out_valid 0, out_last 0, busy 0, done 0, word_count 0, stop_pending 0.
- Reset mid-run aborts immediately, with no done pulse.
- Latency: start at cycle t gives out_valid = 1 and busy = 1 from t+1.
- Throughput: one word per cycle while out_ready = 1.
- Burst of N words with out_ready held high:
  - words at t+1 .. t+N, with out_last at t+N;
  - done at t+N+1;
  - next start accepted from t+N+2.
- stop at cycle u in RUN: out_last is visible from u+1. The word accepted at or after u+1 is the last word.
- stop in the same cycle as a handshake: that handshake's word is not last.
- out_data is registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset values and seeds.** Apply reset, then release. Require all outputs 0. Start mode 10 with burst_len=4, out_ready=1. Require lane 0 words 0x00000001, 0x80200003, 0xC0300002, 0x60180001; lane 1 first word 0x9E3779B8; out_last on the 4th word; done one cycle later.
- **Backpressure.** Burst of 3 with out_ready toggling 1,0,0,1,1. Require data held during the stall cycles, exactly 3 handshakes, and word_count = 3 at done.
- **Free-run with stop.** Mode 01, out_ready=1, stop pulsed on the 5th valid cycle. Require 6 words total, the last with out_last=1, then a done pulse. Start the next run with mode 10: its first word equals lane state 0x?? continuing the sequence, not the seed.
- **Replay determinism.** Run a burst of 5 (mode 10), then a burst of 5 with mode 11. Require the second run to reproduce the first run's 5 words exactly.
- **Edge cases.**
  - burst_len=0: no valid, done at t+1.
  - mode 00 start: no response.
  - start during BURST: ignored, word_count unaffected.
  - reseed in BURST: ignored.
- **Reset mid-burst.** Assert reset on the 3rd word. Require out_valid to drop in the same cycle with no done pulse. After release, a burst restarts from seed 0x00000001.
